// File: rtl/sample_mixer.sv
// Multi-channel audio mixer: snapshots player inputs once per output sample, runs a
// one-channel-per-cycle multiply-accumulate, then saturates into signed 16-bit L/R words.
module sample_mixer #(
  parameter int CHANNELS = 4,
  parameter int TICK_DIV = 2178
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [CHANNELS*8-1:0] ch_sample,
  input  logic [CHANNELS-1:0]   ch_active,
  input  logic [CHANNELS*4-1:0] ch_volume,
  input  logic [CHANNELS*2-1:0] ch_pan,
  input  logic                  master_mute,
  input  logic                  clip_clr,
  output logic [15:0]           audio_l,
  output logic [15:0]           audio_r,
  output logic                  out_valid,
  output logic                  clip
);

  localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CHANNELS - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCUM  = 2'd1;
  localparam logic [1:0] S_OUTPUT = 2'd2;

  logic [1:0]            state;
  logic [DIV_W-1:0]      div_cnt;
  logic                  tick;
  logic [IDX_W-1:0]      idx;
  logic signed [19:0]    acc_l;
  logic signed [19:0]    acc_r;

  logic [CHANNELS*8-1:0] snap_sample;
  logic [CHANNELS-1:0]   snap_active;
  logic [CHANNELS*4-1:0] snap_volume;
  logic [CHANNELS*2-1:0] snap_pan;

  logic [7:0]            cur_sample;
  logic [3:0]            cur_volume;
  logic [1:0]            cur_pan;
  logic                  cur_active;
  logic signed [8:0]     cur_delta;
  logic signed [13:0]    cur_prod;
  logic signed [19:0]    cur_term;

  logic signed [21:0]    scaled_l;
  logic signed [21:0]    scaled_r;
  logic [15:0]           sat_l;
  logic [15:0]           sat_r;
  logic                  clamp_l;
  logic                  clamp_r;

  assign tick = (div_cnt == DIV_LAST);

  // Channel selected by idx, taken from the shadow copy so live inputs cannot disturb a sample.
  assign cur_sample = 8'(snap_sample >> {idx, 3'b000});
  assign cur_volume = 4'(snap_volume >> {idx, 2'b00});
  assign cur_pan    = 2'(snap_pan >> {idx, 1'b0});
  assign cur_active = 1'(snap_active >> idx);
  assign cur_delta  = $signed({1'b0, cur_sample} - 9'd128);
  assign cur_prod   = cur_delta * $signed({1'b0, cur_volume});
  assign cur_term   = cur_active ? {{6{cur_prod[13]}}, cur_prod} : 20'sd0;

  assign scaled_l = {acc_l, 2'b00};
  assign scaled_r = {acc_r, 2'b00};

  always_comb begin
    clamp_l = 1'b1;
    clamp_r = 1'b1;
    sat_l   = scaled_l[15:0];
    sat_r   = scaled_r[15:0];
    if (scaled_l > 22'sd32767)       sat_l = 16'h7fff;
    else if (scaled_l < -22'sd32768) sat_l = 16'h8000;
    else                             clamp_l = 1'b0;
    if (scaled_r > 22'sd32767)       sat_r = 16'h7fff;
    else if (scaled_r < -22'sd32768) sat_r = 16'h8000;
    else                             clamp_r = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_cnt     <= '0;
      state       <= S_IDLE;
      idx         <= '0;
      acc_l       <= '0;
      acc_r       <= '0;
      snap_sample <= '0;
      snap_active <= '0;
      snap_volume <= '0;
      snap_pan    <= '0;
      audio_l     <= '0;
      audio_r     <= '0;
      out_valid   <= 1'b0;
      clip        <= 1'b0;
    end else begin
      div_cnt   <= tick ? '0 : div_cnt + 1'b1;
      out_valid <= 1'b0;
      if (tick) begin
        snap_sample <= ch_sample;
        snap_active <= ch_active;
        snap_volume <= ch_volume;
        snap_pan    <= ch_pan;
      end
      case (state)
        S_IDLE: begin
          if (tick) begin
            state <= S_ACCUM;
            idx   <= '0;
            acc_l <= '0;
            acc_r <= '0;
          end
        end
        S_ACCUM: begin
          if (cur_pan[0]) acc_l <= acc_l + cur_term;
          if (cur_pan[1]) acc_r <= acc_r + cur_term;
          if (idx == IDX_LAST) state <= S_OUTPUT;
          else                 idx   <= idx + 1'b1;
        end
        S_OUTPUT: begin
          // out_valid is a one-cycle strobe with no back-pressure: the consumer must take
          // audio_l/audio_r on the cycle it is high; the words then hold until the next strobe.
          state     <= S_IDLE;
          out_valid <= 1'b1;
          audio_l   <= master_mute ? 16'h0000 : sat_l;
          audio_r   <= master_mute ? 16'h0000 : sat_r;
        end
        default: state <= S_IDLE;
      endcase
      // A clamp in the OUTPUT cycle outranks a simultaneous clear.
      if (state == S_OUTPUT && (clamp_l || clamp_r)) clip <= 1'b1;
      else if (clip_clr)                            clip <= 1'b0;
    end
  end

endmodule
